// File: rtl/lsu_mem_access_if.sv
// Request/response and data-memory bus signals of the LSU memory-access stage.
// slave = the stage itself, master = issue stage plus memory side.
interface lsu_mem_access_if;
    logic        start;
    logic        read_mem;
    logic        write_mem;
    logic [5:0]  ex_type;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [4:0]  rd_in;
    logic        mem_done;
    logic        fault;
    logic [4:0]  rd_wb;
    logic [32:0] load_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport slave (
        input  start, read_mem, write_mem, ex_type, addr, write_data, rd_in,
        input  bus_ack, bus_rdata,
        output mem_done, fault, rd_wb, load_data,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
    );

    modport master (
        output start, read_mem, write_mem, ex_type, addr, write_data, rd_in,
        output bus_ack, bus_rdata,
        input  mem_done, fault, rd_wb, load_data,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
    );
endinterface

// File: rtl/lsu_mem_access.sv
// LSU memory-access stage: alignment check, one req/ack bus transaction, load extend.
// Optional bus_ack watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    lsu_mem_access_if.slave io
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] EX_LB  = 6'd21;
    localparam logic [5:0] EX_LH  = 6'd22;
    localparam logic [5:0] EX_LW  = 6'd23;
    localparam logic [5:0] EX_LBU = 6'd24;
    localparam logic [5:0] EX_LHU = 6'd25;
    localparam logic [5:0] EX_SB  = 6'd26;
    localparam logic [5:0] EX_SH  = 6'd27;
    localparam logic [5:0] EX_SW  = 6'd28;

    logic [1:0]  r_state;
    logic [5:0]  r_ex;
    logic [1:0]  r_alo;
    logic [4:0]  r_rd;
    logic        r_is_read;
    logic        r_mem_done;
    logic        r_fault;
    logic [4:0]  r_rd_wb;
    logic [32:0] r_load_data;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_wstrb;

    logic        w_accept;
    logic        w_misaligned;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_timeout;

    assign w_accept = io.start && (io.read_mem || io.write_mem);

    always_comb begin
        w_misaligned = 1'b0;
        w_wdata      = io.write_data;
        w_wstrb      = 4'b1111;
        case (io.ex_type)
            EX_LH, EX_LHU, EX_SH: w_misaligned = io.addr[0];
            EX_LW, EX_SW:         w_misaligned = |io.addr[1:0];
            default:              w_misaligned = 1'b0;
        endcase
        case (io.ex_type)
            EX_SB: begin
                w_wdata = {4{io.write_data[7:0]}};
                w_wstrb = 4'b0001 << io.addr[1:0];
            end
            EX_SH: begin
                w_wdata = {2{io.write_data[15:0]}};
                w_wstrb = io.addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = io.write_data;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    // Lane selection uses the latched low address bits, not the live input.
    always_comb begin
        w_byte = 8'(io.bus_rdata >> {r_alo, 3'b000});
        w_half = r_alo[1] ? io.bus_rdata[31:16] : io.bus_rdata[15:0];
        case (r_ex)
            EX_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
            EX_LH:   w_ext = {{16{w_half[15]}}, w_half};
            EX_LBU:  w_ext = {24'd0, w_byte};
            EX_LHU:  w_ext = {16'd0, w_half};
            default: w_ext = io.bus_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    assign w_timeout = (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != S_REQ) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ex        <= '0;
            r_alo       <= '0;
            r_rd        <= '0;
            r_is_read   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_fault     <= 1'b0;
            r_rd_wb     <= '0;
            r_load_data <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ex            <= io.ex_type;
                        r_alo           <= io.addr[1:0];
                        r_rd            <= io.rd_in;
                        r_is_read       <= io.read_mem;
                        r_load_data[32] <= 1'b0;
                        if (w_misaligned) begin
                            r_state    <= S_DONE;
                            r_mem_done <= 1'b1;
                            r_fault    <= 1'b1;
                            r_rd_wb    <= '0;
                        end else begin
                            r_state     <= S_REQ;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= ~io.read_mem;
                            r_bus_addr  <= {io.addr[31:2], 2'b00};
                            r_bus_wdata <= w_wdata;
                            r_bus_wstrb <= w_wstrb;
                        end
                    end
                end
                S_REQ: begin
                    // An ack coinciding with the watchdog limit still completes normally.
                    if (io.bus_ack) begin
                        r_state    <= S_DONE;
                        r_bus_req  <= 1'b0;
                        r_mem_done <= 1'b1;
                        r_fault    <= 1'b0;
                        if (r_is_read) begin
                            r_load_data <= {1'b1, w_ext};
                            r_rd_wb     <= r_rd;
                        end
                    end else if (w_timeout) begin
                        r_state    <= S_DONE;
                        r_bus_req  <= 1'b0;
                        r_mem_done <= 1'b1;
                        r_fault    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_mem_done <= 1'b0;
                    r_fault    <= 1'b0;
                    r_rd_wb    <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io.mem_done  = r_mem_done;
    assign io.fault     = r_fault;
    assign io.rd_wb     = r_rd_wb;
    assign io.load_data = r_load_data;
    assign io.bus_req   = r_bus_req;
    assign io.bus_we    = r_bus_we;
    assign io.bus_addr  = r_bus_addr;
    assign io.bus_wdata = r_bus_wdata;
    assign io.bus_wstrb = r_bus_wstrb;
endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: directed cases then randomized requests.
// Define LSU_TIMEOUT_EN to exercise the watchdog path (TIMEOUT_CYCLES = 4).
module tb_lsu_mem_access;
    logic clk;
    logic rst_n;
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;

    lsu_mem_access_if bus ();

    lsu_mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    typedef struct {
        logic        fault;
        logic [4:0]  rd;
        logic [32:0] ld;
        logic        full;
        int unsigned cyc;
    } exp_t;

    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp_v);
        end
    endtask

    function automatic logic is_mis(input logic [5:0] ex, input logic [31:0] a);
        if (ex == 22 || ex == 25 || ex == 27) return (a % 2) != 0;
        if (ex == 23 || ex == 28) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] ex, input logic [31:0] a,
                                               input logic [31:0] w);
        int unsigned off;
        logic [31:0] b;
        logic [31:0] h;
        off = a % 4;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (ex)
            21: return (b >= 32'd128) ? b - 32'd256 : b;
            22: return (h >= 32'd32768) ? h - 32'd65536 : h;
            24: return b;
            25: return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] ex, input logic [31:0] wd);
        if (ex == 26) return (wd & 32'hFF) * 32'h0101_0101;
        if (ex == 27) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [5:0] ex, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        if (ex == 26) return 4'(1 << off);
        if (ex == 27) return (off >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    // Monitor: every mem_done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.mem_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mem_done act=1 exp=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("fault", 64'(bus.fault), 64'(e.fault));
                chk("rd_wb", 64'(bus.rd_wb), 64'(e.rd));
                if (e.full) chk("load_data", 64'(bus.load_data), 64'(e.ld));
                else        chk("load_valid", 64'(bus.load_data[32]), 64'(e.ld[32]));
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic drive_req(input logic [5:0] ex, input logic [31:0] a,
                             input logic [31:0] wd, input logic [4:0] rd);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.read_mem   = (ex <= 25);
        bus.write_mem  = (ex > 25);
        bus.ex_type    = ex;
        bus.addr       = a;
        bus.write_data = wd;
        bus.rd_in      = rd;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.read_mem   = 1'b0;
        bus.write_mem  = 1'b0;
        bus.addr       = $urandom;
        bus.write_data = $urandom;
    endtask

    task automatic do_req(input logic [5:0] ex, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [31:0] rdata, input int unsigned d);
        exp_t e;
        logic mis;
        logic ld;
        mis = is_mis(ex, a);
        ld  = (ex <= 25);
        drive_req(ex, a, wd, rd);
        e.fault = mis;
        e.rd    = (ld && !mis) ? rd : 5'd0;
        e.ld    = {ld && !mis, model_load(ex, a, rdata)};
        e.full  = ld && !mis;
        e.cyc   = mis ? cyc : cyc + d + 1;
        exp_q.push_back(e);
        if (mis) begin
            @(negedge clk);
            chk("mis_no_req", 64'(bus.bus_req), 64'd0);
        end else begin
            for (int unsigned i = 0; i <= d; i++) begin
                @(negedge clk);
                chk("bus_req", 64'(bus.bus_req), 64'd1);
                chk("bus_addr", 64'(bus.bus_addr), 64'(a - (a % 4)));
                chk("bus_we", 64'(bus.bus_we), 64'(!ld));
                if (!ld) begin
                    chk("bus_wdata", 64'(bus.bus_wdata), 64'(model_wdata(ex, wd)));
                    chk("bus_wstrb", 64'(bus.bus_wstrb), 64'(model_wstrb(ex, a)));
                end
                if (i == d) begin
                    bus.bus_ack   = 1'b1;
                    bus.bus_rdata = rdata;
                end
            end
            @(posedge clk);
            #1;
            bus.bus_ack   = 1'b0;
            bus.bus_rdata = $urandom;
        end
        drain();
    endtask

    // Idle gap with stray acks and starts lacking read/write; neither may start a transaction.
    task automatic idle_gap();
        int unsigned n;
        n = $urandom_range(3);
        for (int unsigned i = 0; i <= n; i++) begin
            @(negedge clk);
            chk("idle_no_req", 64'(bus.bus_req), 64'd0);
            bus.bus_ack   = 1'($urandom_range(1));
            bus.bus_rdata = $urandom;
            bus.start     = 1'($urandom_range(1));
        end
        @(negedge clk);
        bus.bus_ack = 1'b0;
        bus.start   = 1'b0;
        @(negedge clk);
        chk("idle_no_req", 64'(bus.bus_req), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout act=hang exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [5:0] ex;
        logic [31:0] a;
        int unsigned acc;
        int unsigned hi;
        cyc = 0;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.read_mem = 1'b0;
        bus.write_mem = 1'b0;
        bus.ex_type = '0;
        bus.addr = '0;
        bus.write_data = '0;
        bus.rd_in = '0;
        bus.bus_ack = 1'b0;
        bus.bus_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_done", 64'(bus.mem_done), 64'd0);
        chk("rst_fault", 64'(bus.fault), 64'd0);
        chk("rst_rd_wb", 64'(bus.rd_wb), 64'd0);
        chk("rst_load_data", 64'(bus.load_data), 64'd0);
        chk("rst_bus_req", 64'(bus.bus_req), 64'd0);
        chk("rst_bus_fields", {bus.bus_we, bus.bus_addr, bus.bus_wdata[27:0], bus.bus_wstrb}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(6'd21, 32'h1003, 32'h0, 5'd5, 32'h80FF_1234, 0);
        idle_gap();
        do_req(6'd25, 32'h2002, 32'h0, 5'd9, 32'hBEEF_0000, 3);
        idle_gap();
        do_req(6'd26, 32'h0011, 32'h0000_00A5, 5'd7, 32'h1234_5678, 1);
        idle_gap();
        do_req(6'd23, 32'h3002, 32'h0, 5'd3, 32'h0, 0);
        idle_gap();

        for (int k = 0; k < 40; k++) begin
            ex = 6'(21 + $urandom_range(7));
            a  = $urandom;
            if ($urandom_range(2) != 0) a[0] = 1'b0;
            do_req(ex, a, $urandom, 5'($urandom), $urandom, $urandom_range(3));
            idle_gap();
        end

        drive_req(6'd23, 32'h40, 32'h0, 5'd4);
        @(negedge clk);
        chk("pre_rst_req", 64'(bus.bus_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 64'(bus.bus_req), 64'd0);
        chk("async_rst_done", 64'(bus.mem_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_req(6'd28, 32'h80, 32'hCAFE_F00D, 5'd2, 32'h0, 1);
        idle_gap();

        drive_req(6'd23, 32'h100, 32'h0, 5'd6);
        acc = cyc;
        hi = 0;
`ifdef LSU_TIMEOUT_EN
        begin
            exp_t e;
            e.fault = 1'b1;
            e.rd    = 5'd0;
            e.ld    = '0;
            e.full  = 1'b0;
            e.cyc   = acc + 4;
            exp_q.push_back(e);
        end
        repeat (8) begin
            @(negedge clk);
            if (bus.bus_req) hi++;
        end
        chk("timeout_req_cycles", 64'(hi), 64'd4);
        drain();
`else
        repeat (20) begin
            @(negedge clk);
            if (bus.bus_req) hi++;
        end
        chk("stall_req_cycles", 64'(hi), 64'd20);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
